// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory responder slice: default widths,
// grant encoding and the word-address range check.
package mips_pkg;

  localparam int unsigned MIPS_DW = 32;
  localparam int unsigned MIPS_AW = 10;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_IF   = 2'd2,
    GNT_DM   = 2'd3
  } gnt_e;

  // A word address is in range only when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter.sv
// Fixed-priority arbiter for loader / fetch / data ports with a fetch
// starvation counter that forces a fetch grant after STARVE_MAX denials.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_we,
  input  logic if_req,
  input  logic dm_req,
  output gnt_e gnt,
  output logic if_ready,
  output logic dm_ready
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // No grants while reset is held, so nothing is accepted or written during reset.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_n)                gnt = GNT_NONE;
    else if (ld_we)            gnt = GNT_LD;
    else if (if_req && starved) gnt = GNT_IF;
    else if (dm_req)           gnt = GNT_DM;
    else if (if_req)           gnt = GNT_IF;
    if_ready = (gnt == GNT_IF);
    dm_ready = (gnt == GNT_DM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 starve_cnt <= '0;
    else if (!if_req || if_ready) starve_cnt <= '0;
    else if (!starved)          starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Word-addressed single-port memory shared by loader, instruction fetch and
// data ports; one access per cycle, responses registered one cycle later.
module mips_mem_responder
  import mips_pkg::*;
#(
  parameter int unsigned AW         = MIPS_AW,
  parameter int unsigned DW         = MIPS_DW,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ready,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          err
);

  gnt_e          gnt;
  logic [31:0]   sel_addr;
  logic          sel_ok;
  logic [AW-1:0] idx;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  mips_mem_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_we    (ld_we),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .gnt      (gnt),
    .if_ready (if_ready),
    .dm_ready (dm_ready)
  );

  always_comb begin
    sel_addr = '0;
    unique case (gnt)
      GNT_LD:  sel_addr = ld_addr;
      GNT_IF:  sel_addr = if_addr;
      GNT_DM:  sel_addr = dm_addr;
      default: sel_addr = '0;
    endcase
    sel_ok  = addr_in_range(sel_addr, AW);
    idx     = sel_addr[AW-1:0];
    wr_en   = sel_ok && ((gnt == GNT_LD) || ((gnt == GNT_DM) && dm_we));
    wr_data = (gnt == GNT_LD) ? ld_data : dm_wdata;
    rd_data = sel_ok ? mem[idx] : '0;
  end

  // Array has no reset; out-of-range writes are simply not enabled.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= (gnt == GNT_IF);
      dm_rvalid <= (gnt == GNT_DM);
      err       <= (gnt != GNT_NONE) && !sel_ok;
      if (gnt == GNT_IF) if_rdata <= rd_data;
      if (gnt == GNT_DM) dm_rdata <= dm_we ? '0 : rd_data;
    end
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Word-addressed single-port memory responder that services the pipeline's two memory initiators: instruction fetch (IF) and data load/store (MEM stage). A third loader port lets the bench or boot logic write program/data images before or while the core runs. It replaces the bare shared Mem array with an arbitrated, handshaked slave, and it lives beside the pipeline core in the same clock domain.

Parameters:
AW, 10, word-address width; array depth is 2**AW words (1024 by default).
DW, 32, data word width.
STARVE_MAX, 3, number of consecutive fetch denials after which fetch wins arbitration.

Ports:
clk  in  1  single system clock; all logic is posedge.
rst_n  in  1  synchronous active-low reset.
ld_we  in  1  loader write strobe; highest priority; no ready signal.
ld_addr  in  32  loader word address.
ld_data  in  DW  loader write data.
if_req  in  1  fetch request valid.
if_addr  in  32  fetch word address (PC).
if_ready  out  1  fetch request accepted this cycle.
if_rvalid  out  1  fetch read data valid.
if_rdata  out  DW  fetched instruction.
dm_req  in  1  data request valid.
dm_we  in  1  1 = store, 0 = load.
dm_addr  in  32  data word address (ALUOUT).
dm_wdata  in  DW  store data.
dm_ready  out  1  data request accepted this cycle.
dm_rvalid  out  1  load data valid, or store acknowledge.
dm_rdata  out  DW  load data (0 on store acknowledge).
err  out  1  one-cycle pulse on an out-of-range access by any port.

Behaviour:
- Reset (rst_n=0 at a posedge): if_ready, dm_ready, if_rvalid, dm_rvalid, err = 0; if_rdata, dm_rdata = 0; starvation counter = 0. Array contents are not reset.
- Ready outputs are combinational from the current requests and the arbiter state. At most one port touches the array per cycle.
- Priority each cycle:
  1. ld_we beats everything; if_ready = dm_ready = 0.
  2. Otherwise, if starve_cnt == STARVE_MAX and if_req, fetch wins.
  3. Otherwise dm_req wins over if_req.
- Starvation counter:
  - increments (saturating at STARVE_MAX) each cycle if_req=1 and if_ready=0;
  - clears on any cycle fetch is granted or if_req=0.
- A transaction is accepted on the cycle req & ready is high.
  - Read: rvalid pulses exactly 1 cycle later, with rdata = array[addr] as of the acceptance cycle.
  - Store: the write commits at the acceptance edge; dm_rvalid pulses 1 cycle later with dm_rdata = 0.
- rvalid is a single-cycle pulse. rdata holds its last value when rvalid=0. Requesters must not depend on rdata outside rvalid.
- Back-to-back: a new request may be accepted every cycle; responses stay in order per port. A read in the cycle after a write to the same address returns the new data.
- Loader writes commit at the edge where ld_we=1 and produce no response.
- Range check: any address with nonzero bits [31:AW] is out of range.
  - Writes are dropped; reads respond normally with rdata = 0.
  - err pulses 1 cycle after acceptance, or 1 cycle after ld_we for the loader.
- Requests held with req=1 and ready=0 must keep their addr/we/wdata stable; the block does not latch them.
- Reset asserted mid-transaction: pending rvalid and err pulses are cancelled and no response is issued. A write already committed before reset stays in the array.

Decomposition:
- Shared package mips_pkg: DW, the default AW, and the port-grant encoding GNT_NONE/GNT_LD/GNT_IF/GNT_DM (2 bits).
- One sub-module, mips_mem_arbiter: the priority logic plus starvation counter; outputs the grant and the ready signals.
- The top level holds the array, range check, and response registers.

Test Plan:
1. Reset, then loader writes 0x20010005 at address 4; fetch reads address 4 -> if_ready=1 in the request cycle; if_rvalid=1 the next cycle with if_rdata=0x20010005.
2. if_req and dm_req (load, address 8) held together continuously -> dm granted for 3 cycles, fetch granted on the 4th cycle (STARVE_MAX=3), then dm resumes; every response arrives 1 cycle after its grant.
3. Store 0xDEADBEEF to address 12, then load address 12 on the next cycle -> dm_rvalid ack with dm_rdata=0, then dm_rvalid with dm_rdata=0xDEADBEEF.
4. ld_we asserted in the same cycle as dm_req and if_req -> both ready signals low that cycle; the loader data is committed; the dm request is granted the following cycle.
5. Load from address 0x00000400 (AW=10) -> dm_rvalid with dm_rdata=0 and err=1 in the same cycle; a store to 0x400 leaves array[0] unchanged.
6. Pull rst_n low in the cycle after a load is accepted -> no dm_rvalid; after reset, all outputs are 0 and the starvation counter is 0.
